// File: rtl/hdc_pkg.sv
// Shared hypervector definitions for the bundler, datapath and class-vector memory.
package hdc_pkg;

  localparam int HDC_DIM      = 128;
  localparam int HDC_NUM_FEAT = 16;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    QUANT  = 2'd1,
    STREAM = 2'd2
  } state_e;

  typedef logic [HDC_DIM-1:0] hv_t;

endpackage

// File: rtl/hdc_majority.sv
// Per-dimension majority threshold: compares 2*cnt against n, falling back to the tie bit.
module hdc_majority #(
  parameter int CNT_W = 5
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] n,
  input  logic             tie,
  output logic             q
);

  // One extra bit so doubling cnt can never wrap.
  logic [CNT_W:0] twice_cnt;
  logic [CNT_W:0] n_ext;

  assign twice_cnt = {cnt, 1'b0};
  assign n_ext     = {1'b0, n};

  always_comb begin
    q = tie;
    if (twice_cnt > n_ext) begin
      q = 1'b1;
    end else if (twice_cnt < n_ext) begin
      q = 1'b0;
    end
  end

endmodule

// File: rtl/query_bundler.sv
// Bundles up to NUM_FEAT hypervectors by per-dimension majority vote and streams
// the quantized query out one bit per clock, index 0 first.
module query_bundler
  import hdc_pkg::*;
#(
  parameter int DIM      = HDC_DIM,
  parameter int NUM_FEAT = HDC_NUM_FEAT,
  parameter int CNT_W    = $clog2(NUM_FEAT + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DIM-1:0] in_hv,
  input  logic           in_last,
  output logic           out_start,
  output logic           out_valid,
  output logic           out_bit,
  output logic           out_last,
  output logic           busy
);

  // Handshake: an input is consumed on a rising edge where in_valid && in_ready;
  // upstream must hold in_hv/in_last stable until then. The output stream has no
  // backpressure: out_bit is valid whenever out_valid is high.

  localparam int BIT_W = (DIM > 1) ? $clog2(DIM) : 1;

  state_e           state;
  logic [CNT_W-1:0] cnt [DIM];
  logic [CNT_W-1:0] feat_cnt;
  logic [DIM-1:0]   tie_vec;
  logic [DIM-1:0]   sr;
  logic [DIM-1:0]   q;
  logic [BIT_W-1:0] bit_idx;
  logic             accept;
  logic             feat_full;
  logic             bit_final;

  assign accept    = in_valid && in_ready;
  assign feat_full = (feat_cnt + CNT_W'(1)) == CNT_W'(NUM_FEAT);
  assign bit_final = bit_idx == BIT_W'(DIM - 1);

  assign in_ready  = (state == ACCUM);
  assign out_start = (state == QUANT);
  assign out_valid = (state == STREAM);
  assign out_bit   = (state == STREAM) && sr[0];
  assign out_last  = (state == STREAM) && bit_final;
  assign busy      = (state == QUANT) || (state == STREAM);

  genvar g;
  for (g = 0; g < DIM; g++) begin : g_maj
    hdc_majority #(
      .CNT_W(CNT_W)
    ) u_maj (
      .cnt(cnt[g]),
      .n  (feat_cnt),
      .tie(tie_vec[g]),
      .q  (q[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      feat_cnt <= '0;
      tie_vec  <= '0;
      sr       <= '0;
      bit_idx  <= '0;
      for (int i = 0; i < DIM; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            for (int i = 0; i < DIM; i++) begin
              cnt[i] <= cnt[i] + CNT_W'(in_hv[i]);
            end
            feat_cnt <= feat_cnt + CNT_W'(1);
            // The first vector of a query decides every tied dimension.
            if (feat_cnt == '0) begin
              tie_vec <= in_hv;
            end
            if (in_last || feat_full) begin
              state <= QUANT;
            end
          end
        end
        QUANT: begin
          sr       <= q;
          feat_cnt <= '0;
          bit_idx  <= '0;
          for (int i = 0; i < DIM; i++) begin
            cnt[i] <= '0;
          end
          state <= STREAM;
        end
        STREAM: begin
          sr      <= sr >> 1;
          bit_idx <= bit_idx + BIT_W'(1);
          if (bit_final) begin
            state <= ACCUM;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_query_bundler.sv
// Randomized bench for query_bundler with a majority-vote reference model and result queue.
module tb_query_bundler;
  import hdc_pkg::*;

  localparam int DIM      = HDC_DIM;
  localparam int NUM_FEAT = HDC_NUM_FEAT;
  localparam int TMO      = 400;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [DIM-1:0] in_hv;
  logic           in_last;
  logic           out_start;
  logic           out_valid;
  logic           out_bit;
  logic           out_last;
  logic           busy;

  int             total = 0;
  int             bad   = 0;
  int             cyc   = 0;
  int             last_acc = 0;
  logic [DIM-1:0] exp_q[$];

  query_bundler #(
    .DIM     (DIM),
    .NUM_FEAT(NUM_FEAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_hv    (in_hv),
    .in_last  (in_last),
    .out_start(out_start),
    .out_valid(out_valid),
    .out_bit  (out_bit),
    .out_last (out_last),
    .busy     (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Majority vote per dimension over the whole query; ties take the first vector.
  function automatic hv_t model(input hv_t vs[$]);
    hv_t r;
    int  n;
    n = vs.size();
    for (int i = 0; i < DIM; i++) begin
      int ones;
      ones = 0;
      foreach (vs[k]) ones += int'(vs[k][i]);
      if (2 * ones > n)      r[i] = 1'b1;
      else if (2 * ones < n) r[i] = 1'b0;
      else                   r[i] = vs[0][i];
    end
    return r;
  endfunction

  function automatic hv_t rand_hv();
    hv_t v;
    for (int w = 0; w < DIM / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input hv_t hv, input logic last);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    in_hv    = hv;
    in_last  = last;
    k = 0;
    while (!in_ready && k < TMO) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k >= TMO) begin
      bad++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Follows one QUANT + STREAM sequence starting the cycle after the last accept.
  task automatic collect(input string name, output hv_t got);
    int errs;
    got = '0;
    @(negedge clk);
    total++;
    if (out_start !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_start: start=%b ready=%b busy=%b valid=%b, required 1 0 1 0",
               name, out_start, in_ready, busy, out_valid);
    end
    errs = 0;
    for (int i = 0; i < DIM; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_start !== 1'b0 ||
          out_last !== (i == DIM - 1)) errs++;
      got[i] = out_bit;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s_stream_protocol: %0d bad cycles, required 0", name, errs);
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL %s_return: ready=%b valid=%b busy=%b last=%b, required 1 0 0 0",
               name, in_ready, out_valid, busy, out_last);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_hv = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b, required 1", in_ready);
    end
    total++;
    if ({out_start, out_valid, out_bit, out_last, busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b, required 00000",
               {out_start, out_valid, out_bit, out_last, busy});
    end
  endtask

  task automatic test_single();
    hv_t v, got, e;
    v = {(DIM/8){8'hA5}};
    exp_q.push_back(v);
    send(v, 1'b1);
    collect("single", got);
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++; $display("FAIL single_result: got %h, required %h", got, e);
    end
  endtask

  task automatic test_majority3();
    hv_t vs[$];
    hv_t got, e;
    vs = '{'1, '1, '0};
    exp_q.push_back(model(vs));
    send(vs[0], 1'b0);
    send(vs[1], 1'b0);
    send(vs[2], 1'b1);
    collect("maj3", got);
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++; $display("FAIL maj3_result: got %h, required %h", got, e);
    end
  endtask

  task automatic test_tie();
    hv_t v0, got, e;
    v0 = {(DIM/8){8'hF0}};
    exp_q.push_back(v0);
    send(v0, 1'b0);
    send(~v0, 1'b1);
    collect("tie", got);
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++; $display("FAIL tie_result: got %h, required %h", got, e);
    end
  endtask

  task automatic test_cap();
    hv_t vs[$];
    hv_t v17, got, e;
    int  cap_acc;
    for (int k = 0; k < NUM_FEAT; k++) vs.push_back(rand_hv());
    v17 = rand_hv();
    exp_q.push_back(model(vs));
    exp_q.push_back(v17);
    foreach (vs[k]) send(vs[k], 1'b0);
    cap_acc = last_acc;
    // The 17th vector is offered throughout STREAM and must wait.
    in_valid = 1'b1; in_hv = v17; in_last = 1'b1;
    collect("cap", got);
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++; $display("FAIL cap_result: got %h, required %h", got, e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    total++;
    if (cyc - cap_acc != DIM + 2) begin
      bad++; $display("FAIL cap_next_accept: gap %0d, required %0d", cyc - cap_acc, DIM + 2);
    end
    collect("cap17", got);
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++; $display("FAIL cap17_result: got %h, required %h", got, e);
    end
  endtask

  task automatic test_back_to_back();
    hv_t a[$];
    hv_t b[$];
    hv_t got, e;
    int  a_acc;
    for (int k = 0; k < 3; k++) a.push_back(rand_hv());
    for (int k = 0; k < 2; k++) b.push_back(rand_hv());
    exp_q.push_back(model(a));
    exp_q.push_back(model(b));
    send(a[0], 1'b0);
    send(a[1], 1'b0);
    send(a[2], 1'b1);
    a_acc = last_acc;
    in_valid = 1'b1; in_hv = b[0]; in_last = 1'b0;
    collect("b2b_a", got);
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++; $display("FAIL b2b_a_result: got %h, required %h", got, e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (cyc - a_acc != DIM + 2) begin
      bad++; $display("FAIL b2b_first_accept: gap %0d, required %0d", cyc - a_acc, DIM + 2);
    end
    send(b[1], 1'b1);
    collect("b2b_b", got);
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++; $display("FAIL b2b_b_result: got %h, required %h", got, e);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      hv_t vs[$];
      hv_t got, e;
      int  n;
      n = (r == 0) ? NUM_FEAT : $urandom_range(1, NUM_FEAT);
      vs = {};
      for (int k = 0; k < n; k++) vs.push_back(rand_hv());
      exp_q.push_back(model(vs));
      for (int k = 0; k < n; k++) send(vs[k], k == n - 1);
      collect("rand", got);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++; $display("FAIL rand_result n=%0d: got %h, required %h", n, got, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    hv_t v, got, e;
    int  last_seen;
    v = rand_hv();
    send(v, 1'b1);
    repeat (1 + 40 + 1) @(negedge clk);
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL rstmid_streaming: valid=%b, required 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_start, out_valid, out_bit, out_last, busy} !== 5'b0) begin
      bad++;
      $display("FAIL rstmid_outputs: got %b, required 00000",
               {out_start, out_valid, out_bit, out_last, busy});
    end
    last_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_last !== 1'b0 || out_valid !== 1'b0) last_seen++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (last_seen != 0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_release: stray=%0d ready=%b last=%b, required 0 1 0",
               last_seen, in_ready, out_last);
    end
    v = rand_hv();
    exp_q.push_back(v);
    send(v, 1'b1);
    collect("rstmid_q", got);
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++; $display("FAIL rstmid_result: got %h, required %h", got, e);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_majority3();
    test_tie();
    test_cap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_left: %0d entries, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
